// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game sequencer: LFSR mole placement, hit/miss flashes, BCD score, round count.
// Optional macro WRONG_PENALTY_EN: a wrong-hole whack also decrements the score.
//
// state | meaning
// IDLE  | after reset, waiting for start, outputs 0
// SHOW  | mole up, waiting for a whack or the mole timeout
// FLASH | guess_correct/guess_wrong held, whacks ignored
// OVER  | all rounds played, score held, waiting for start
module mole_game_ctrl #(
   parameter int         MOLE_TICKS  = 4,
   parameter int         FLASH_TICKS = 2,
   parameter int         ROUNDS      = 20,
   parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       start,
   input  logic       whack_valid,
   input  logic [2:0] whack_pos,
   output logic [2:0] mole_position,
   output logic       guess_correct,
   output logic       guess_wrong,
   output logic [3:0] digit_1,
   output logic [3:0] digit_2,
   output logic       game_over
);

   typedef enum logic [1:0] {IDLE, SHOW, FLASH, OVER} state_t;

   localparam logic [15:0] MOLE_LD  = 16'(MOLE_TICKS);
   localparam logic [15:0] FLASH_LD = 16'(FLASH_TICKS);
   localparam logic [7:0]  ROUNDS_C = 8'(ROUNDS);

   state_t      state, state_nxt;
   logic [7:0]  lfsr, lfsr_nxt;
   logic [15:0] tmr, tmr_nxt;
   logic [7:0]  round, round_nxt;
   logic [7:0]  score, score_nxt;
   logic [2:0]  mole_nxt, new_mole;
   logic        gc_nxt, gw_nxt, over_nxt;

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      if (v == 8'h99)
         return v;
      if (v[3:0] == 4'd9)
         return {v[7:4] + 4'd1, 4'd0};
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [7:0] v);
      if (v == 8'h00)
         return v;
      if (v[3:0] == 4'd0)
         return {v[7:4] - 4'd1, 4'd9};
      return {v[7:4], v[3:0] - 4'd1};
   endfunction

   assign lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   // never repeat the hole the mole was just in
   assign new_mole = (lfsr[2:0] == mole_position) ? lfsr[2:0] + 3'd1 : lfsr[2:0];

   always_comb begin
      state_nxt = state;
      tmr_nxt   = tmr;
      round_nxt = round;
      score_nxt = score;
      mole_nxt  = mole_position;
      gc_nxt    = guess_correct;
      gw_nxt    = guess_wrong;
      over_nxt  = game_over;
      case (state)
         IDLE, OVER: begin
            if (start) begin
               score_nxt = 8'h00;
               round_nxt = 8'd0;
               mole_nxt  = new_mole;
               tmr_nxt   = MOLE_LD;
               over_nxt  = 1'b0;
               state_nxt = SHOW;
            end
         end
         SHOW: begin
            if (whack_valid) begin
               tmr_nxt   = FLASH_LD;
               state_nxt = FLASH;
               if (whack_pos == mole_position) begin
                  score_nxt = bcd_inc(score);
                  gc_nxt    = 1'b1;
               end else begin
                  gw_nxt = 1'b1;
`ifdef WRONG_PENALTY_EN
                  score_nxt = bcd_dec(score);
`endif
               end
            end else if (tick) begin
               if (tmr == 16'd1) begin
                  gw_nxt    = 1'b1;
                  tmr_nxt   = FLASH_LD;
                  state_nxt = FLASH;
               end else begin
                  tmr_nxt = tmr - 16'd1;
               end
            end
         end
         FLASH: begin
            if (tick) begin
               if (tmr == 16'd1) begin
                  gc_nxt    = 1'b0;
                  gw_nxt    = 1'b0;
                  round_nxt = round + 8'd1;
                  if (round + 8'd1 == ROUNDS_C) begin
                     over_nxt  = 1'b1;
                     state_nxt = OVER;
                  end else begin
                     mole_nxt  = new_mole;
                     tmr_nxt   = MOLE_LD;
                     state_nxt = SHOW;
                  end
               end else begin
                  tmr_nxt = tmr - 16'd1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         lfsr          <= LFSR_SEED;
         tmr           <= 16'd0;
         round         <= 8'd0;
         score         <= 8'h00;
         mole_position <= 3'd0;
         guess_correct <= 1'b0;
         guess_wrong   <= 1'b0;
         game_over     <= 1'b0;
      end else begin
         state         <= state_nxt;
         lfsr          <= lfsr_nxt;
         tmr           <= tmr_nxt;
         round         <= round_nxt;
         score         <= score_nxt;
         mole_position <= mole_nxt;
         guess_correct <= gc_nxt;
         guess_wrong   <= gw_nxt;
         game_over     <= over_nxt;
      end
   end

   assign digit_1 = score[7:4];
   assign digit_2 = score[3:0];

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Self-checking bench for mole_game_ctrl: directed vector table, full-game run, random play
// against a behavioural game model. ROUNDS is raised so a single game can reach score 99.
module tb_mole_game_ctrl;

   localparam int MT   = 4;
   localparam int FT   = 2;
   localparam int R_TB = 102;
`ifdef WRONG_PENALTY_EN
   localparam int PEN = 1;
`else
   localparam int PEN = 0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       tick, start, whack_valid;
   logic [2:0] whack_pos;
   logic [2:0] mole_position;
   logic       guess_correct, guess_wrong, game_over;
   logic [3:0] digit_1, digit_2;

   int checks = 0;
   int errors = 0;

   mole_game_ctrl #(.MOLE_TICKS(MT), .FLASH_TICKS(FT), .ROUNDS(R_TB), .LFSR_SEED(8'hA5)) dut (
      .clk(clk), .rst(rst), .tick(tick), .start(start),
      .whack_valid(whack_valid), .whack_pos(whack_pos),
      .mole_position(mole_position), .guess_correct(guess_correct),
      .guess_wrong(guess_wrong), .digit_1(digit_1), .digit_2(digit_2),
      .game_over(game_over)
   );

   always #5 clk = ~clk;

   // behavioural game model: integer score, counting-up waits, flags for game phase
   logic [7:0] m_lfsr;
   logic [2:0] m_mole;
   logic       m_gc, m_gw, m_over;
   bit         m_playing, m_flashing;
   int         m_score, m_waited, m_flashed, m_rounds;

   task automatic model_reset();
      m_lfsr = 8'hA5; m_mole = 3'd0; m_gc = 1'b0; m_gw = 1'b0; m_over = 1'b0;
      m_playing = 0; m_flashing = 0;
      m_score = 0; m_waited = 0; m_flashed = 0; m_rounds = 0;
   endtask

   task automatic model_step(input logic s, input logic wv, input logic [2:0] wp, input logic tk);
      logic [2:0] pick;
      pick = m_lfsr[2:0];
      if (pick == m_mole) pick = pick + 3'd1;
      if (!m_playing) begin
         if (s) begin
            m_score = 0; m_rounds = 0; m_mole = pick; m_waited = 0;
            m_over = 1'b0; m_playing = 1;
         end
      end else if (!m_flashing) begin
         if (wv) begin
            if (wp == m_mole) begin
               m_score = (m_score + 1 > 99) ? 99 : m_score + 1;
               m_gc = 1'b1;
            end else begin
               m_gw = 1'b1;
               if (PEN == 1 && m_score > 0) m_score = m_score - 1;
            end
            m_flashing = 1; m_flashed = 0;
         end else if (tk) begin
            m_waited++;
            if (m_waited == MT) begin
               m_gw = 1'b1; m_flashing = 1; m_flashed = 0;
            end
         end
      end else if (tk) begin
         m_flashed++;
         if (m_flashed == FT) begin
            m_gc = 1'b0; m_gw = 1'b0; m_flashing = 0;
            m_rounds++;
            if (m_rounds == R_TB) begin
               m_over = 1'b1; m_playing = 0;
            end else begin
               m_mole = pick; m_waited = 0;
            end
         end
      end
      m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic compare_all();
      chk("mole_position", int'(mole_position), int'(m_mole));
      chk("guess_correct", int'(guess_correct), int'(m_gc));
      chk("guess_wrong",   int'(guess_wrong),   int'(m_gw));
      chk("digit_1",       int'(digit_1),       m_score / 10);
      chk("digit_2",       int'(digit_2),       m_score % 10);
      chk("game_over",     int'(game_over),     int'(m_over));
      chk("guess_exclusive", int'(guess_correct & guess_wrong), 0);
   endtask

   task automatic step(input logic s, input logic wv, input logic [2:0] wp, input logic tk);
      start = s; whack_valid = wv; whack_pos = wp; tick = tk;
      @(posedge clk);
      model_step(s, wv, wp, tk);
      #1;
      start = 1'b0; whack_valid = 1'b0; tick = 1'b0;
      compare_all();
   endtask

   task automatic pulse_reset();
      #2 rst = 1'b1;
      model_reset();
      #1 compare_all();
      #1 rst = 1'b0;
   endtask

   typedef struct {
      logic s, wv, hit, tk;
      logic gc, gw;
      int   sc;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input logic s, input logic wv, input logic hit, input logic tk,
                      input logic gc, input logic gw, input int sc);
      vec_t v;
      v.s = s; v.wv = wv; v.hit = hit; v.tk = tk; v.gc = gc; v.gw = gw; v.sc = sc;
      tbl.push_back(v);
   endtask

   initial begin
      logic [2:0] wp;
      int exp_sc;
      rst = 1'b1; tick = 1'b0; start = 1'b0; whack_valid = 1'b0; whack_pos = 3'd0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      rst = 1'b0;

      //  s     wv    hit   tk    gc    gw    score
      add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1);
      add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1);
      add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
      add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1);
      add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1 - PEN);
      add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1 - PEN);
      add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1 - PEN);
      add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1 - PEN);
      add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1 - PEN);
      add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1 - PEN);
      add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1 - PEN);
      add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1 - PEN);
      add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1 - PEN);
      add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1 - PEN);
      add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1 - PEN);
      add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2 - PEN);
      add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2 - PEN);
      add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2 - PEN);

      foreach (tbl[i]) begin
         wp = tbl[i].hit ? m_mole : m_mole + 3'd1;
         step(tbl[i].s, tbl[i].wv, wp, tbl[i].tk);
         chk($sformatf("tbl%0d_gc", i), int'(guess_correct), int'(tbl[i].gc));
         chk($sformatf("tbl%0d_gw", i), int'(guess_wrong), int'(tbl[i].gw));
         chk($sformatf("tbl%0d_score", i), int'(digit_1) * 10 + int'(digit_2), tbl[i].sc);
         chk($sformatf("tbl%0d_over", i), int'(game_over), 0);
      end

      // fresh game: wrong hole at 00 stays 00, then hit every remaining mole
      pulse_reset();
      step(1'b1, 1'b0, 3'd0, 1'b0);
      step(1'b0, 1'b1, m_mole + 3'd1, 1'b0);
      chk("wrong_at_00_gw", int'(guess_wrong), 1);
      chk("wrong_at_00_score", int'(digit_1) * 10 + int'(digit_2), 0);
      step(1'b0, 1'b0, 3'd0, 1'b1);
      step(1'b0, 1'b0, 3'd0, 1'b1);
      for (int r = 1; r < R_TB; r++) begin
         step(1'b0, 1'b1, m_mole, 1'b0);
         exp_sc = (r > 99) ? 99 : r;
         chk($sformatf("run_hit%0d_d1", r), int'(digit_1), exp_sc / 10);
         chk($sformatf("run_hit%0d_d2", r), int'(digit_2), exp_sc % 10);
         step(1'b0, 1'b0, 3'd0, 1'b1);
         step(1'b0, 1'b0, 3'd0, 1'b1);
      end
      chk("end_game_over", int'(game_over), 1);
      chk("end_score", int'(digit_1) * 10 + int'(digit_2), 99);
      step(1'b0, 1'b1, m_mole, 1'b1);
      chk("over_whack_ignored_gc", int'(guess_correct), 0);
      chk("over_hold_score", int'(digit_1) * 10 + int'(digit_2), 99);
      step(1'b1, 1'b0, 3'd0, 1'b0);
      chk("restart_over", int'(game_over), 0);
      chk("restart_score", int'(digit_1) * 10 + int'(digit_2), 0);

      // whack lands on the same cycle as the timeout tick: the hit wins
      step(1'b0, 1'b0, 3'd0, 1'b1);
      step(1'b0, 1'b0, 3'd0, 1'b1);
      step(1'b0, 1'b0, 3'd0, 1'b1);
      step(1'b0, 1'b1, m_mole, 1'b1);
      chk("tie_gc", int'(guess_correct), 1);
      chk("tie_gw", int'(guess_wrong), 0);
      step(1'b0, 1'b0, 3'd0, 1'b1);
      step(1'b0, 1'b0, 3'd0, 1'b1);

      for (int c = 0; c < 2000; c++) begin
         logic s, wv, tk;
         s  = ($urandom_range(0, 29) == 0);
         wv = ($urandom_range(0, 4) == 0);
         tk = ($urandom_range(0, 2) == 0);
         wp = $urandom_range(0, 1) ? m_mole : 3'($urandom_range(0, 7));
         if (c == 0 || c == 900) s = 1'b1;
         step(s, wv, wp, tk);
         if (c == 800) pulse_reset();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
